alu_nibble_sequencer: RTL and testbench

//  Drives the 4-bit daisy-chained alu_slice core (4 slices, LSB slice takes carry in) to

---
 rtl/alu_nibble_sequencer_if.sv | 30 +++
 rtl/alu_nibble_sequencer.sv | 175 +++++++++++++++++
 tb/tb_alu_nibble_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/alu_nibble_sequencer_if.sv
// Request/result handshake bundle between the execute stage and the nibble sequencer.
// master = execute-stage requester/consumer, slave = sequencer.
interface alu_nibble_sequencer_if #(
  parameter int NIBBLES = 2
);
  localparam int W = 4 * NIBBLES;

  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [2:0]   op_sel;
  logic         cy_in;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] result;
  logic         flag_c;
  logic         flag_h;
  logic         flag_z;

  modport master (
    output req_valid, op_a, op_b, op_sel, cy_in, res_ready,
    input  req_ready, res_valid, result, flag_c, flag_h, flag_z
  );

  modport slave (
    input  req_valid, op_a, op_b, op_sel, cy_in, res_ready,
    output req_ready, res_valid, result, flag_c, flag_h, flag_z
  );
endinterface

// File: rtl/alu_nibble_sequencer.sv
// Sequences a wide ADD/ADC/XOR/AND/OR through a 4-bit combinational ALU core,
// one nibble per cycle LSB first, assembling the result and C/H/Z flags.
module alu_nibble_sequencer #(
  parameter int NIBBLES = 2
) (
  input  logic                         clk,
  input  logic                         nreset,
  alu_nibble_sequencer_if.slave        bus,
  output logic [3:0]                   alu_op1,
  output logic [3:0]                   alu_op2,
  output logic                         alu_cy_in,
  output logic                         alu_R,
  output logic                         alu_S,
  output logic                         alu_V,
  input  logic [3:0]                   alu_result,
  input  logic                         alu_cy_out
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 2) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  typedef enum logic [2:0] {K_ADD, K_ADC, K_XOR, K_AND, K_OR} kind_t;

  function automatic kind_t decode_op(input logic [2:0] sel);
    case (sel)
      3'd1:    return K_ADC;
      3'd2:    return K_XOR;
      3'd3:    return K_AND;
      3'd4:    return K_OR;
      default: return K_ADD;
    endcase
  endfunction

  // {R, S, V, fixed cin}; the cin bit is only meaningful for the logic ops.
  function automatic logic [3:0] core_ctrl(input kind_t k);
    case (k)
      K_XOR:   return 4'b1000;
      K_AND:   return 4'b0101;
      K_OR:    return 4'b1110;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [3:0] nibble_of(input logic [W-1:0] v, input logic [CW-1:0] idx);
    logic [3:0] n;
    n = v[3:0];
    for (int k = 1; k < NIBBLES; k++)
      if (idx == CW'(k)) n = v[4*k +: 4];
    return n;
  endfunction

  state_t        state_q;
  kind_t         kind_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  op_a_q, op_b_q;
  logic [W-1:0]  result_q;
  logic          cy_q;
  logic          c_q, h_q, z_q;
  logic          req_ready_q, res_valid_q;
  logic [3:0]    alu_op1_q, alu_op2_q;
  logic          alu_cy_in_q, alu_r_q, alu_s_q, alu_v_q;

  logic [W-1:0]  result_d;
  logic [CW-1:0] cnt_d;
  logic          arith;
  kind_t         kind_d;
  logic [3:0]    ctrl_d;

  always_comb begin
    result_d = result_q;
    for (int k = 0; k < NIBBLES; k++)
      if (cnt_q == CW'(k)) result_d[4*k +: 4] = alu_result;
    cnt_d  = cnt_q + 1'b1;
    arith  = (kind_q == K_ADD) || (kind_q == K_ADC);
    kind_d = decode_op(bus.op_sel);
    ctrl_d = core_ctrl(kind_d);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= S_IDLE;
      kind_q      <= K_ADD;
      cnt_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      result_q    <= '0;
      cy_q        <= 1'b0;
      c_q         <= 1'b0;
      h_q         <= 1'b0;
      z_q         <= 1'b0;
      req_ready_q <= 1'b1;
      res_valid_q <= 1'b0;
      alu_op1_q   <= '0;
      alu_op2_q   <= '0;
      alu_cy_in_q <= 1'b0;
      alu_r_q     <= 1'b0;
      alu_s_q     <= 1'b0;
      alu_v_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            state_q     <= S_RUN;
            kind_q      <= kind_d;
            cnt_q       <= '0;
            op_a_q      <= bus.op_a;
            op_b_q      <= bus.op_b;
            req_ready_q <= 1'b0;
            // Nibble 0 is presented to the core already in the first RUN cycle.
            alu_op1_q   <= bus.op_a[3:0];
            alu_op2_q   <= bus.op_b[3:0];
            alu_r_q     <= ctrl_d[3];
            alu_s_q     <= ctrl_d[2];
            alu_v_q     <= ctrl_d[1];
            alu_cy_in_q <= (kind_d == K_ADC) ? bus.cy_in : ctrl_d[0];
          end
        end
        S_RUN: begin
          result_q <= result_d;
          cy_q     <= alu_cy_out;
          if (cnt_q == '0)
            h_q <= arith ? alu_cy_out : (kind_q == K_AND);
          if (cnt_q == LAST) begin
            state_q     <= S_DONE;
            res_valid_q <= 1'b1;
            c_q         <= arith & alu_cy_out;
            z_q         <= (result_d == '0);
            alu_op1_q   <= '0;
            alu_op2_q   <= '0;
            alu_cy_in_q <= 1'b0;
            alu_r_q     <= 1'b0;
            alu_s_q     <= 1'b0;
            alu_v_q     <= 1'b0;
          end else begin
            cnt_q     <= cnt_d;
            alu_op1_q <= nibble_of(op_a_q, cnt_d);
            alu_op2_q <= nibble_of(op_b_q, cnt_d);
            if (arith) alu_cy_in_q <= alu_cy_out;
          end
        end
        S_DONE: begin
          if (bus.res_ready) begin
            state_q     <= S_IDLE;
            res_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.result    = result_q;
  assign bus.flag_c    = c_q;
  assign bus.flag_h    = h_q;
  assign bus.flag_z    = z_q;

  assign alu_op1   = alu_op1_q;
  assign alu_op2   = alu_op2_q;
  assign alu_cy_in = alu_cy_in_q;
  assign alu_R     = alu_r_q;
  assign alu_S     = alu_s_q;
  assign alu_V     = alu_v_q;

  // Inter-nibble carry is also forwarded via alu_cy_in_q; cy_q keeps the raw latched value.
  logic unused_cy;
  assign unused_cy = cy_q;
endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Directed bench for alu_nibble_sequencer (NIBBLES=2) with a behavioural 4-bit ALU core.
module tb_alu_nibble_sequencer;
  logic clk = 1'b0;
  logic nreset;
  logic [3:0] alu_op1, alu_op2, alu_result;
  logic alu_cy_in, alu_R, alu_S, alu_V, alu_cy_out;

  int n_vec = 0;
  int n_err = 0;
  int lat;

  alu_nibble_sequencer_if #(.NIBBLES(2)) bus();

  alu_nibble_sequencer #(.NIBBLES(2)) dut (
    .clk        (clk),
    .nreset     (nreset),
    .bus        (bus),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .alu_cy_in  (alu_cy_in),
    .alu_R      (alu_R),
    .alu_S      (alu_S),
    .alu_V      (alu_V),
    .alu_result (alu_result),
    .alu_cy_out (alu_cy_out)
  );

  always #5 clk = ~clk;

  // Behavioural 4-slice core: R/S/V select add, xor, and, or.
  logic [4:0] core_sum;
  always_comb begin
    core_sum   = {1'b0, alu_op1} + {1'b0, alu_op2} + {4'b0, alu_cy_in};
    alu_result = core_sum[3:0];
    alu_cy_out = core_sum[4];
    if (alu_R && !alu_S) begin
      alu_result = alu_op1 ^ alu_op2;
      alu_cy_out = 1'b0;
    end else if (!alu_R && alu_S) begin
      alu_result = alu_op1 & alu_op2;
      alu_cy_out = alu_cy_in;
    end else if (alu_R && alu_S && alu_V) begin
      alu_result = alu_op1 | alu_op2;
      alu_cy_out = 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one request, scramble inputs after accept, wait for res_valid (bounded).
  task automatic issue(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b,
                       input logic c, output int cycles);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.op_sel    = sel;
    bus.op_a      = a;
    bus.op_b      = b;
    bus.cy_in     = c;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.op_a      = ~a;
    bus.op_b      = ~b;
    bus.cy_in     = ~c;
    bus.op_sel    = 3'd3;
    cycles = 1;
    while (!bus.res_valid && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic release_result();
    @(negedge clk);
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [2:0] sel, input logic [7:0] a,
                        input logic [7:0] b, input logic c, input logic [7:0] exp_r,
                        input logic ec, input logic eh, input logic ez);
    int cyc;
    issue(sel, a, b, c, cyc);
    check_eq({tag, "_valid"}, bus.res_valid, 1'b1);
    check_eq({tag, "_result"}, bus.result, exp_r);
    check_eq({tag, "_chz"}, {bus.flag_c, bus.flag_h, bus.flag_z}, {ec, eh, ez});
    release_result();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.res_ready = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.op_sel    = '0;
    bus.cy_in     = 1'b0;
    nreset        = 1'b0;
    #12;
    check_eq("rst_ready", bus.req_ready, 1'b1);
    check_eq("rst_valid", bus.res_valid, 1'b0);
    check_eq("rst_result", bus.result, 8'h00);
    check_eq("rst_flags", {bus.flag_c, bus.flag_h, bus.flag_z}, 3'b000);
    check_eq("rst_alu", {alu_op1, alu_op2, alu_cy_in, alu_R, alu_S, alu_V}, 12'h000);
    @(negedge clk);
    nreset = 1'b1;

    // ADD with latency and DONE-state core outputs
    issue(3'd0, 8'h2B, 8'h15, 1'b0, lat);
    check_eq("add_latency", lat, 3);
    check_eq("add_result", bus.result, 8'h40);
    check_eq("add_chz", {bus.flag_c, bus.flag_h, bus.flag_z}, 3'b010);
    check_eq("done_alu_zero", {alu_op1, alu_op2, alu_cy_in, alu_R, alu_S, alu_V}, 12'h000);
    check_eq("done_ready", bus.req_ready, 1'b0);
    release_result();
    check_eq("hs_valid_low", bus.res_valid, 1'b0);
    check_eq("hs_ready_high", bus.req_ready, 1'b1);

    run_op("adc", 3'd1, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1);
    run_op("add_ff", 3'd0, 8'hFF, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    run_op("xor", 3'd2, 8'h36, 8'h63, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    run_op("or", 3'd4, 8'h30, 8'h05, 1'b0, 8'h35, 1'b0, 1'b0, 1'b0);
    run_op("and", 3'd3, 8'h0F, 8'hF0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    run_op("sel6", 3'd6, 8'h01, 8'h01, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0);

    // Back-pressure in DONE with a competing request
    issue(3'd0, 8'h11, 8'h22, 1'b0, lat);
    check_eq("bp_valid", bus.res_valid, 1'b1);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.op_sel    = 3'd0;
    bus.op_a      = 8'h05;
    bus.op_b      = 8'h07;
    bus.cy_in     = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_eq("bp_result", bus.result, 8'h33);
      check_eq("bp_flags", {bus.flag_c, bus.flag_h, bus.flag_z}, 3'b000);
      check_eq("bp_ready", bus.req_ready, 1'b0);
      check_eq("bp_hold", bus.res_valid, 1'b1);
    end
    @(negedge clk);
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    check_eq("bp_hs_valid", bus.res_valid, 1'b0);
    check_eq("bp_hs_ready", bus.req_ready, 1'b1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check_eq("bp_reaccept", bus.req_ready, 1'b0);
    lat = 1;
    while (!bus.res_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("bp_next_result", bus.result, 8'h0C);
    check_eq("bp_next_chz", {bus.flag_c, bus.flag_h, bus.flag_z}, 3'b000);
    release_result();

    // Reset during RUN (cnt=1) aborts the operation
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.op_sel    = 3'd4;
    bus.op_a      = 8'h30;
    bus.op_b      = 8'h05;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("mid_run_alu", {alu_op1, alu_op2, alu_R, alu_S, alu_V}, {4'h3, 4'h0, 3'b111});
    #2;
    nreset = 1'b0;
    #1;
    check_eq("abort_valid", bus.res_valid, 1'b0);
    check_eq("abort_ready", bus.req_ready, 1'b1);
    check_eq("abort_alu", {alu_op1, alu_op2, alu_cy_in, alu_R, alu_S, alu_V}, 12'h000);
    check_eq("abort_result", bus.result, 8'h00);
    @(negedge clk);
    nreset = 1'b1;
    run_op("post_rst", 3'd0, 8'h2B, 8'h15, 1'b0, 8'h40, 1'b0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
